// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, queue entry layout and the
// canonical NOP encoding consumed by later stages.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [31:0] INSTR_NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } iq_entry_t;

endpackage

// File: rtl/fetch_ptr.sv
// Wrap-bit ring pointer: optional reload (flush) followed by an optional
// increment in the same cycle.
module fetch_ptr #(
  parameter int PW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [PW:0] load_val,
  input  logic        inc,
  output logic [PW:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= (load ? load_val : ptr) + {{PW{1'b0}}, inc};
  end

endmodule

// File: rtl/fetch1_ifq.sv
// F1 fetch queue: issues in-order imem requests for the F0 PC stream, collects
// responses into an in-order queue for decode, and throttles F0 via credits.
module fetch1_ifq #(
  parameter int XLEN     = fetch_pkg::XLEN,
  parameter int ILEN     = fetch_pkg::ILEN,
  parameter int IQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f0_valid_i,
  input  logic [XLEN-1:0] f0_pc_i,
  output logic            stall_f0_o,
  input  logic            redir_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [ILEN-1:0] imem_resp_data_i,
  output logic            f1_valid_o,
  output logic [XLEN-1:0] f1_pc_o,
  output logic [ILEN-1:0] f1_instr_o,
  input  logic            f1_ready_i
);

  localparam int PW = $clog2(IQ_DEPTH);
  typedef logic [PW:0] ptr_t;

  // Entry fields kept as separate arrays so their widths follow the parameters.
  logic [XLEN-1:0]     pc_q    [IQ_DEPTH];
  logic [ILEN-1:0]     instr_q [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] filled;

  ptr_t          alloc, fill, head, drop_cnt;
  ptr_t          used, outstanding;
  logic [PW+1:0] occ;
  logic          credit_ok, fire, resp_take, pop;

  assign used        = alloc - head;
  assign outstanding = alloc - fill;
  // Stale in-flight responses still hold a slot until they drain.
  assign occ         = {1'b0, used} + {1'b0, drop_cnt};
  assign credit_ok   = occ < (PW+2)'(IQ_DEPTH);

  assign imem_req_valid_o = f0_valid_i & credit_ok;
  assign imem_req_addr_o  = f0_pc_i;
  assign stall_f0_o       = ~credit_ok | ~imem_req_ready_i;
  assign fire             = imem_req_valid_o & imem_req_ready_i;

  assign resp_take  = imem_resp_valid_i & ~redir_i & (drop_cnt == '0);
  assign f1_valid_o = filled[head[PW-1:0]] & (used != '0) & ~redir_i;
  assign pop        = f1_valid_o & f1_ready_i;
  assign f1_pc_o    = f1_valid_o ? pc_q[head[PW-1:0]]    : '0;
  assign f1_instr_o = f1_valid_o ? instr_q[head[PW-1:0]] : '0;

  // A flush collapses fill/head onto alloc; a same-cycle request then lands
  // at alloc as the first entry of the new path.
  fetch_ptr #(.PW(PW)) u_alloc (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val('0), .inc(fire), .ptr(alloc)
  );
  fetch_ptr #(.PW(PW)) u_fill (
    .clk(clk), .rst_n(rst_n), .load(redir_i), .load_val(alloc), .inc(resp_take), .ptr(fill)
  );
  fetch_ptr #(.PW(PW)) u_head (
    .clk(clk), .rst_n(rst_n), .load(redir_i), .load_val(alloc), .inc(pop), .ptr(head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (redir_i) begin
      drop_cnt <= drop_cnt + outstanding - ptr_t'(imem_resp_valid_i);
    end else if (imem_resp_valid_i && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - ptr_t'(1);
    end
  end

  // alloc and fill never alias while a response is being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filled <= '0;
    end else begin
      if (fire)      filled[alloc[PW-1:0]] <= 1'b0;
      if (resp_take) filled[fill[PW-1:0]]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fire)      pc_q[alloc[PW-1:0]]   <= f0_pc_i;
    if (resp_take) instr_q[fill[PW-1:0]] <= imem_resp_data_i;
  end

endmodule

// File: tb/tb_fetch1_ifq.sv
// Bench for fetch1_ifq: F0 driver, in-order imem model with programmable
// latency, and a scoreboard of expected decode-side entries.
module tb_fetch1_ifq;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            f0_valid_i = 1'b0;
  logic [XLEN-1:0] f0_pc_i = '0;
  logic            stall_f0_o;
  logic            redir_i = 1'b0;
  logic            imem_req_valid_o;
  logic            imem_req_ready_i = 1'b1;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_resp_valid_i = 1'b0;
  logic [ILEN-1:0] imem_resp_data_i = '0;
  logic            f1_valid_o;
  logic [XLEN-1:0] f1_pc_o;
  logic [ILEN-1:0] f1_instr_o;
  logic            f1_ready_i = 1'b0;

  always #5 clk = ~clk;

  fetch1_ifq #(.XLEN(XLEN), .ILEN(ILEN), .IQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .f0_valid_i(f0_valid_i), .f0_pc_i(f0_pc_i), .stall_f0_o(stall_f0_o),
    .redir_i(redir_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i), .imem_resp_data_i(imem_resp_data_i),
    .f1_valid_o(f1_valid_o), .f1_pc_o(f1_pc_o), .f1_instr_o(f1_instr_o),
    .f1_ready_i(f1_ready_i)
  );

  typedef struct {
    logic [XLEN-1:0] pc;
    int              due;
    bit              stale;
  } req_t;

  req_t            pend[$];
  logic [XLEN-1:0] sb_q[$];
  logic [XLEN-1:0] fire_log[$];
  logic [XLEN-1:0] pop_log[$];
  int  m_filled = 0, cyc = 0, lat = 1, last_due = 0;
  bit  cur_stale = 1'b0;
  int  n_tests = 0, n_fail = 0;

  bit              o_fire, o_pop, o_stall, o_f1v;
  logic [XLEN-1:0] o_addr, o_pop_pc;
  logic [ILEN-1:0] o_pop_instr;

  function automatic logic [ILEN-1:0] ifn(input logic [XLEN-1:0] pc);
    return pc[ILEN-1:0] ^ 32'h5A5A_0000;
  endfunction

  // Per-cycle reference model, evaluated mid-cycle on settled signals.
  task automatic monitor();
    int stale_now;
    int d;
    bit credit, exp_v, fire;
    if (!rst_n) begin
      pend.delete(); sb_q.delete(); m_filled = 0; cur_stale = 1'b0;
      o_fire = 1'b0; o_pop = 1'b0; o_f1v = 1'b0; o_stall = stall_f0_o; o_addr = imem_req_addr_o;
    end else begin
      stale_now = (imem_resp_valid_i && cur_stale) ? 1 : 0;
      foreach (pend[i]) if (pend[i].stale) stale_now++;
      credit = (sb_q.size() + stale_now) < DEPTH;
      n_tests++;
      if (imem_req_valid_o !== (f0_valid_i & credit)) begin
        n_fail++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid_o, f0_valid_i & credit);
      end
      n_tests++;
      if (stall_f0_o !== (~credit | ~imem_req_ready_i)) begin
        n_fail++; $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall_f0_o, ~credit | ~imem_req_ready_i);
      end
      n_tests++;
      if (imem_req_addr_o !== f0_pc_i) begin
        n_fail++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr_o, f0_pc_i);
      end
      exp_v = (m_filled > 0) && !redir_i;
      n_tests++;
      if (f1_valid_o !== exp_v) begin
        n_fail++; $display("FAIL f1_valid cyc=%0d got=%b exp=%b", cyc, f1_valid_o, exp_v);
      end
      n_tests++;
      if (int'(dut.used) + int'(dut.drop_cnt) > DEPTH) begin
        n_fail++; $display("FAIL credit_leak cyc=%0d got=%0d exp<=%0d", cyc, int'(dut.used) + int'(dut.drop_cnt), DEPTH);
      end
      fire    = imem_req_valid_o & imem_req_ready_i;
      o_fire  = fire;
      o_addr  = imem_req_addr_o;
      o_stall = stall_f0_o;
      o_f1v   = f1_valid_o;
      o_pop   = f1_valid_o & f1_ready_i;
      if (o_pop) begin
        o_pop_pc = f1_pc_o; o_pop_instr = f1_instr_o;
        pop_log.push_back(f1_pc_o);
        n_tests++;
        if (sb_q.size() == 0 || m_filled == 0) begin
          n_fail++; $display("FAIL pop_empty cyc=%0d got_pc=%h exp=no_entry", cyc, f1_pc_o);
        end else begin
          if (f1_pc_o !== sb_q[0] || f1_instr_o !== ifn(sb_q[0])) begin
            n_fail++;
            $display("FAIL pop_data cyc=%0d got=%h/%h exp=%h/%h", cyc, f1_pc_o, f1_instr_o, sb_q[0], ifn(sb_q[0]));
          end
          void'(sb_q.pop_front());
          m_filled--;
        end
      end
      if (redir_i) begin
        sb_q.delete(); m_filled = 0;
        foreach (pend[i]) pend[i].stale = 1'b1;
      end else if (imem_resp_valid_i && !cur_stale) begin
        m_filled++;
      end
      if (fire) begin
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pend.push_back('{pc: imem_req_addr_o, due: d, stale: 1'b0});
        sb_q.push_back(imem_req_addr_o);
        fire_log.push_back(imem_req_addr_o);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n && o_fire) f0_pc_i = f0_pc_i + 64'd4;
    if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = ifn(pend[0].pc);
      cur_stale         = pend[0].stale;
      void'(pend.pop_front());
    end else begin
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = '0;
      cur_stale         = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; f0_valid_i = 1'b0; redir_i = 1'b0; f1_ready_i = 1'b0;
    imem_req_ready_i = 1'b1;
    step(); step();
    rst_n = 1'b1;
    last_due = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready_i = 1'b0; f0_valid_i = 1'b1; f1_ready_i = 1'b1; redir_i = 1'b0;
    #1;
    n_tests++;
    if (f1_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_f1_valid got=%b exp=0", f1_valid_o); end
    n_tests++;
    if (stall_f0_o !== 1'b1) begin n_fail++; $display("FAIL rst_stall_notready got=%b exp=1", stall_f0_o); end
    n_tests++;
    if (imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_req_valid got=%b exp=1", imem_req_valid_o); end
    n_tests++;
    if (f1_pc_o !== '0 || f1_instr_o !== '0) begin
      n_fail++; $display("FAIL rst_f1_data got=%h/%h exp=0/0", f1_pc_o, f1_instr_o);
    end
    imem_req_ready_i = 1'b1; #1;
    n_tests++;
    if (stall_f0_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall_ready got=%b exp=0", stall_f0_o); end
    f0_valid_i = 1'b0; #1;
    n_tests++;
    if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_idle got=%b exp=0", imem_req_valid_o); end
  endtask

  task automatic test_stream();
    int first_fire, first_v, stalls, p0;
    do_reset();
    lat = 1; f1_ready_i = 1'b1; f0_pc_i = 64'h1000; f0_valid_i = 1'b1;
    first_fire = -1; first_v = -1; stalls = 0; p0 = pop_log.size();
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_fire && first_fire < 0) first_fire = i;
      if (o_f1v && first_v < 0) first_v = i;
      if (o_stall) stalls++;
    end
    n_tests++;
    if (first_fire != 0 || first_v != 2) begin
      n_fail++; $display("FAIL stream_latency got=%0d/%0d exp=0/2", first_fire, first_v);
    end
    n_tests++;
    if (stalls != 0) begin n_fail++; $display("FAIL stream_stall got=%0d exp=0", stalls); end
    n_tests++;
    if (pop_log.size() - p0 != 18) begin
      n_fail++; $display("FAIL stream_pops got=%0d exp=18", pop_log.size() - p0);
    end else begin
      n_tests++;
      if (pop_log[p0] !== 64'h1000 || pop_log[p0+17] !== 64'h1044) begin
        n_fail++; $display("FAIL stream_order got=%h..%h exp=1000..1044", pop_log[p0], pop_log[p0+17]);
      end
    end
  endtask

  task automatic test_full();
    int f0, nf, bad;
    do_reset();
    lat = 1; f1_ready_i = 1'b0; f0_pc_i = 64'h1000; f0_valid_i = 1'b1;
    f0 = fire_log.size(); nf = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (nf == 4 && !o_stall) bad++;
      if (o_fire) nf++;
    end
    n_tests++;
    if (nf != 4 || fire_log[f0+3] !== 64'h100C) begin
      n_fail++; $display("FAIL full_reqs got=%0d last=%h exp=4 last=100c", nf, fire_log[fire_log.size()-1]);
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL full_stall got=%0d_unstalled exp=0", bad); end
    f1_ready_i = 1'b1; step(); f1_ready_i = 1'b0;
    n_tests++;
    if (!o_pop || o_pop_pc !== 64'h1000) begin
      n_fail++; $display("FAIL full_pop got=%b/%h exp=1/1000", o_pop, o_pop_pc);
    end
    step();
    n_tests++;
    if (!o_fire || o_addr !== 64'h1010) begin
      n_fail++; $display("FAIL full_refill got=%b/%h exp=1/1010", o_fire, o_addr);
    end
    nf = 0;
    for (int i = 0; i < 3; i++) begin step(); if (o_fire) nf++; end
    n_tests++;
    if (nf != 0) begin n_fail++; $display("FAIL full_hold got=%0d exp=0", nf); end
  endtask

  task automatic test_redirect_drop();
    int p0, t;
    do_reset();
    lat = 4; f1_ready_i = 1'b1; f0_pc_i = 64'h1000; f0_valid_i = 1'b1;
    step(); step(); step();
    redir_i = 1'b1; f0_pc_i = 64'h8000;
    step();
    redir_i = 1'b0;
    n_tests++;
    if (!o_fire || o_addr !== 64'h8000) begin
      n_fail++; $display("FAIL redir_target got=%b/%h exp=1/8000", o_fire, o_addr);
    end
    n_tests++;
    if (dut.drop_cnt !== 3'd3) begin n_fail++; $display("FAIL redir_drop_cnt got=%0d exp=3", dut.drop_cnt); end
    p0 = pop_log.size(); t = 0;
    while (pop_log.size() == p0 && t < 30) begin step(); t++; end
    n_tests++;
    if (pop_log.size() == p0) begin
      n_fail++; $display("FAIL redir_first_pop got=timeout exp=8000");
    end else if (o_pop_pc !== 64'h8000 || o_pop_instr !== 32'h5A5A8000) begin
      n_fail++; $display("FAIL redir_first_pop got=%h/%h exp=8000/5a5a8000", o_pop_pc, o_pop_instr);
    end
  endtask

  task automatic test_redir_resp();
    int p0;
    do_reset();
    lat = 2; f1_ready_i = 1'b0; f0_pc_i = 64'h3000; f0_valid_i = 1'b1;
    step(); step(); step();
    f0_valid_i = 1'b0; redir_i = 1'b1; f0_pc_i = 64'h9000;
    n_tests++;
    if (imem_resp_valid_i !== 1'b1) begin n_fail++; $display("FAIL rr_setup got=%b exp=1", imem_resp_valid_i); end
    step();
    redir_i = 1'b0;
    n_tests++;
    if (o_f1v !== 1'b0) begin n_fail++; $display("FAIL rr_f1_valid got=%b exp=0", o_f1v); end
    n_tests++;
    if (dut.drop_cnt !== 3'd1) begin n_fail++; $display("FAIL rr_drop_cnt got=%0d exp=1", dut.drop_cnt); end
    f1_ready_i = 1'b1; p0 = pop_log.size();
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (pop_log.size() != p0 || dut.drop_cnt !== 3'd0) begin
      n_fail++; $display("FAIL rr_drain got=%0d_pops/%0d exp=0/0", pop_log.size() - p0, dut.drop_cnt);
    end
  endtask

  task automatic test_ready_low();
    int f0;
    do_reset();
    lat = 1; f1_ready_i = 1'b1; f0_pc_i = 64'h2000; f0_valid_i = 1'b1; imem_req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (!o_stall || o_fire || o_addr !== 64'h2000) begin
        n_fail++; $display("FAIL rdy_hold cyc=%0d got=%b/%b/%h exp=1/0/2000", i, o_stall, o_fire, o_addr);
      end
    end
    imem_req_ready_i = 1'b1; f0 = fire_log.size();
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (fire_log.size() - f0 != 4) begin
      n_fail++; $display("FAIL rdy_count got=%0d exp=4", fire_log.size() - f0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (fire_log[f0+i] !== 64'h2000 + 64'(4*i)) begin
          n_fail++; $display("FAIL rdy_seq idx=%0d got=%h exp=%h", i, fire_log[f0+i], 64'h2000 + 64'(4*i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 1; f1_ready_i = 1'b0; f0_pc_i = 64'h4000; f0_valid_i = 1'b1;
    step(); step(); step();
    n_tests++;
    if (dut.used !== 3'd3) begin n_fail++; $display("FAIL b2b_used_pre got=%0d exp=3", dut.used); end
    f1_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (!o_fire || !o_pop || !cur_stale && 1'b0 || dut.used !== 3'd3) begin
        n_fail++; $display("FAIL b2b_used cyc=%0d got=%b/%b/%0d exp=1/1/3", i, o_fire, o_pop, dut.used);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 4; f1_ready_i = 1'b0; f0_pc_i = 64'h5000; f0_valid_i = 1'b1;
    step(); step(); step();
    f0_valid_i = 1'b0; redir_i = 1'b1; step(); redir_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (dut.used !== '0 || dut.drop_cnt !== '0 || dut.filled !== '0 || f1_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got=%0d/%0d/%b/%b exp=0/0/0/0", dut.used, dut.drop_cnt, dut.filled, f1_valid_o);
    end
    step();
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    f0_pc_i = 64'h10000; p0 = pop_log.size();
    for (int i = 0; i < 1000; i++) begin
      f0_valid_i       = ($urandom_range(0, 3) != 0);
      imem_req_ready_i = ($urandom_range(0, 3) != 0);
      f1_ready_i       = ($urandom_range(0, 2) != 0);
      lat              = $urandom_range(1, 3);
      redir_i          = ($urandom_range(0, 19) == 0);
      if (redir_i) f0_pc_i = 64'h20000 + (64'($urandom_range(0, 1023)) << 2);
      step();
    end
    redir_i = 1'b0; f0_valid_i = 1'b0; f1_ready_i = 1'b1; imem_req_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    n_tests++;
    if (pop_log.size() - p0 < 100) begin
      n_fail++; $display("FAIL rand_progress got=%0d_pops exp>=100", pop_log.size() - p0);
    end
    n_tests++;
    if (dut.used !== '0 || dut.drop_cnt !== '0) begin
      n_fail++; $display("FAIL rand_drain got=%0d/%0d exp=0/0", dut.used, dut.drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redir_resp();
    test_ready_low();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
